// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: one byte-enabled write port and two read ports.
interface regfile_param_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic               we;
  logic [WIDTH/8-1:0] be;
  logic [AW-1:0]      waddr;
  logic [WIDTH-1:0]   wdata;
  logic               re1, re2;
  logic [AW-1:0]      ra1, ra2;
  logic [WIDTH-1:0]   rd1, rd2;

  modport master (output we, be, waddr, wdata, re1, re2, ra1, ra2, input rd1, rd2);
  modport slave  (input we, be, waddr, wdata, re1, re2, ra1, ra2, output rd1, rd2);
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: byte-enabled write port, two registered read ports,
// optional same-cycle write forwarding and hard-wired zero register.
module regfile_param_rdport #(
  parameter int WIDTH    = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             re_i,
  input  logic [AW-1:0]    ra_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] merged_i,
  input  logic [WIDTH-1:0] word_i,
  output logic [WIDTH-1:0] rd_o
);
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             ra_dead;

  assign ra_dead = (int'(ra_i) >= DEPTH) || (ZERO_REG && (ra_i == '0));

  always_comb begin
    rd_d = rd_q;
    if (re_i) begin
      if (ra_dead)                                       rd_d = '0;
      else if (BYPASS && wr_en_i && (waddr_i == ra_i))   rd_d = merged_i;
      else                                               rd_d = word_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign rd_o = rd_q;
endmodule

module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  regfile_param_if.slave bus
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB    = WIDTH / 8;
  localparam int NPORT = 2;

  logic [WIDTH-1:0]             mem_q [DEPTH];
  logic                         waddr_ok, wr_en;
  logic [WIDTH-1:0]             cur, merged;
  logic [NPORT-1:0]             re;
  logic [NPORT-1:0][AW-1:0]     ra;
  logic [NPORT-1:0][WIDTH-1:0]  word, rd;

  assign waddr_ok = int'(bus.waddr) < DEPTH;
  assign wr_en    = bus.we && waddr_ok && !(ZERO_REG && (bus.waddr == '0));
  assign cur      = waddr_ok ? mem_q[bus.waddr] : '0;

  // merged is exactly the word being stored; the read ports forward it too
  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign merged[8*b +: 8] = bus.be[b] ? bus.wdata[8*b +: 8] : cur[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[bus.waddr] <= merged;
    end
  end

  assign re = {bus.re2, bus.re1};
  assign ra = {bus.ra2, bus.ra1};

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign word[p] = (int'(ra[p]) < DEPTH) ? mem_q[ra[p]] : '0;
    regfile_param_rdport #(
      .WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .clk      (clk),
      .reset    (reset),
      .re_i     (re[p]),
      .ra_i     (ra[p]),
      .wr_en_i  (wr_en),
      .waddr_i  (bus.waddr),
      .merged_i (merged),
      .word_i   (word[p]),
      .rd_o     (rd[p])
    );
  end

  assign bus.rd1 = rd[0];
  assign bus.rd2 = rd[1];
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: five configurations driven by one stimulus stream,
// checked by a scoreboard fed from a word-level reference model.
module tb_regfile_param;
  localparam int ND = 5;
  int cfg_w  [ND] = '{32, 32, 32, 64, 64};
  int cfg_d  [ND] = '{32, 32, 20, 16, 16};
  int cfg_b  [ND] = '{1, 0, 1, 1, 0};
  int cfg_aw [ND] = '{5, 5, 5, 4, 4};

  logic        clk = 1'b0;
  logic        s_rst, s_we, s_re1, s_re2;
  logic [7:0]  s_be, s_waddr, s_ra1, s_ra2;
  logic [63:0] s_wdata;

  initial forever #5 clk = ~clk;

  regfile_param_if #(.WIDTH(32), .AW(5)) if0 ();
  regfile_param_if #(.WIDTH(32), .AW(5)) if1 ();
  regfile_param_if #(.WIDTH(32), .AW(5)) if2 ();
  regfile_param_if #(.WIDTH(64), .AW(4)) if3 ();
  regfile_param_if #(.WIDTH(64), .AW(4)) if4 ();

  assign if0.we = s_we; assign if0.be = s_be[3:0]; assign if0.waddr = s_waddr[4:0]; assign if0.wdata = s_wdata[31:0];
  assign if0.re1 = s_re1; assign if0.re2 = s_re2; assign if0.ra1 = s_ra1[4:0]; assign if0.ra2 = s_ra2[4:0];
  assign if1.we = s_we; assign if1.be = s_be[3:0]; assign if1.waddr = s_waddr[4:0]; assign if1.wdata = s_wdata[31:0];
  assign if1.re1 = s_re1; assign if1.re2 = s_re2; assign if1.ra1 = s_ra1[4:0]; assign if1.ra2 = s_ra2[4:0];
  assign if2.we = s_we; assign if2.be = s_be[3:0]; assign if2.waddr = s_waddr[4:0]; assign if2.wdata = s_wdata[31:0];
  assign if2.re1 = s_re1; assign if2.re2 = s_re2; assign if2.ra1 = s_ra1[4:0]; assign if2.ra2 = s_ra2[4:0];
  assign if3.we = s_we; assign if3.be = s_be; assign if3.waddr = s_waddr[3:0]; assign if3.wdata = s_wdata;
  assign if3.re1 = s_re1; assign if3.re2 = s_re2; assign if3.ra1 = s_ra1[3:0]; assign if3.ra2 = s_ra2[3:0];
  assign if4.we = s_we; assign if4.be = s_be; assign if4.waddr = s_waddr[3:0]; assign if4.wdata = s_wdata;
  assign if4.re1 = s_re1; assign if4.re2 = s_re2; assign if4.ra1 = s_ra1[3:0]; assign if4.ra2 = s_ra2[3:0];

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u0 (.clk(clk), .reset(s_rst), .bus(if0));
  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) u1 (.clk(clk), .reset(s_rst), .bus(if1));
  regfile_param #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1'b1), .BYPASS(1'b1)) u2 (.clk(clk), .reset(s_rst), .bus(if2));
  regfile_param #(.WIDTH(64), .DEPTH(16), .ZERO_REG(1'b1), .BYPASS(1'b1)) u3 (.clk(clk), .reset(s_rst), .bus(if3));
  regfile_param #(.WIDTH(64), .DEPTH(16), .ZERO_REG(1'b1), .BYPASS(1'b0)) u4 (.clk(clk), .reset(s_rst), .bus(if4));

  typedef struct { int d; int p; logic [63:0] exp; } exp_t;
  exp_t exp_q [$];
  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] m_mem [ND][256];
  logic [63:0] m_rd  [ND][2];

  // Reference: apply one clock edge to every configuration's word array and read regs
  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      int          amask, wa;
      int          ra [2];
      logic        re [2];
      logic        wr;
      logic [63:0] nw;
      exp_t        e;
      if (s_rst) begin
        for (int a = 0; a < 256; a++) m_mem[d][a] = '0;
        m_rd[d][0] = '0;
        m_rd[d][1] = '0;
      end else begin
        amask = (1 << cfg_aw[d]) - 1;
        wa    = int'(s_waddr) & amask;
        ra[0] = int'(s_ra1) & amask;
        ra[1] = int'(s_ra2) & amask;
        re[0] = s_re1;
        re[1] = s_re2;
        wr    = s_we && (wa < cfg_d[d]) && (wa != 0);
        nw    = m_mem[d][wa];
        for (int b = 0; b < cfg_w[d] / 8; b++)
          if (s_be[b]) nw[8*b +: 8] = s_wdata[8*b +: 8];
        for (int p = 0; p < 2; p++) begin
          if (re[p]) begin
            if (ra[p] >= cfg_d[d] || ra[p] == 0)          m_rd[d][p] = '0;
            else if (cfg_b[d] != 0 && wr && wa == ra[p])  m_rd[d][p] = nw;
            else                                          m_rd[d][p] = m_mem[d][ra[p]];
          end
        end
        if (wr) m_mem[d][wa] = nw;
      end
      for (int p = 0; p < 2; p++) begin
        e.d = d; e.p = p; e.exp = m_rd[d][p];
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic logic [63:0] dut_rd(input int d, input int p);
    case (d)
      0:       return (p == 0) ? 64'(if0.rd1) : 64'(if0.rd2);
      1:       return (p == 0) ? 64'(if1.rd1) : 64'(if1.rd2);
      2:       return (p == 0) ? 64'(if2.rd1) : 64'(if2.rd2);
      3:       return (p == 0) ? if3.rd1 : if3.rd2;
      default: return (p == 0) ? if4.rd1 : if4.rd2;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = dut_rd(e.d, e.p);
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL sb dut%0d.rd%0d: got %h want %h at %0t", e.d, e.p + 1, act, e.exp, $time);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(input int we, input int be, input int wa, input logic [63:0] wd,
                     input int re1, input int ra1, input int re2, input int ra2);
    s_we = 1'(we); s_be = 8'(be); s_waddr = 8'(wa); s_wdata = wd;
    s_re1 = 1'(re1); s_ra1 = 8'(ra1); s_re2 = 1'(re2); s_ra2 = 8'(ra2);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  initial begin
    s_rst = 1'b1;
    drv(0, 0, 0, 64'h0, 0, 0, 0, 0);
    cycle(); cycle();
    chk("reset.rd1", 64'(if0.rd1), 64'h0);
    chk("reset.rd2", 64'(if0.rd2), 64'h0);
    chk("reset.w64", if3.rd1, 64'h0);
    s_rst = 1'b0;

    drv(1, 'hF, 5, 64'hA213D22F, 0, 0, 0, 0); cycle();
    drv(0, 0, 0, 64'h0, 1, 5, 0, 0);          cycle();
    chk("basic.rd1", 64'(if0.rd1), 64'hA213D22F);

    drv(1, 'h5, 5, 64'h3324DFA1, 0, 0, 0, 0); cycle();
    drv(0, 0, 0, 64'h0, 1, 5, 0, 0);          cycle();
    chk("be0101", 64'(if0.rd1), 64'hA224D2A1);
    drv(1, 'h0, 5, 64'hFFFFFFFF, 0, 0, 0, 0); cycle();
    drv(0, 0, 0, 64'h0, 1, 5, 0, 0);          cycle();
    chk("be0000", 64'(if0.rd1), 64'hA224D2A1);

    drv(1, 'hF, 7, 64'h12353ABC, 1, 7, 1, 7); cycle();
    chk("byp1.rd1", 64'(if0.rd1), 64'h12353ABC);
    chk("byp1.rd2", 64'(if0.rd2), 64'h12353ABC);
    chk("byp0.rd1.old", 64'(if1.rd1), 64'h0);
    chk("byp0.rd2.old", 64'(if1.rd2), 64'h0);
    drv(0, 0, 0, 64'h0, 1, 7, 1, 7); cycle();
    chk("byp0.reread", 64'(if1.rd1), 64'h12353ABC);

    drv(1, 'hF, 0,  64'hFFFFFFFF, 0, 0, 0, 0); cycle();
    drv(1, 'hF, 25, 64'hFFFFFFFF, 0, 0, 0, 0); cycle();
    drv(1, 'hF, 19, 64'h01234567, 0, 0, 0, 0); cycle();
    drv(0, 0, 0, 64'h0, 1, 0, 1, 25);          cycle();
    chk("zero.rd1", 64'(if2.rd1), 64'h0);
    chk("range.rd2", 64'(if2.rd2), 64'h0);
    chk("d32.addr25", 64'(if0.rd2), 64'hFFFFFFFF);
    drv(0, 0, 0, 64'h0, 1, 19, 0, 0);          cycle();
    chk("top.rd1", 64'(if2.rd1), 64'h01234567);

    drv(1, 'hF, 3, 64'hDEADBEEF, 0, 0, 0, 0); cycle();
    drv(0, 0, 0, 64'h0, 1, 3, 0, 0);          cycle();
    chk("hold.pre", 64'(if0.rd1), 64'hDEADBEEF);
    drv(1, 'hF, 3, 64'h11111111, 0, 3, 0, 0); cycle(); cycle();
    chk("hold.rd1", 64'(if0.rd1), 64'hDEADBEEF);

    s_rst = 1'b1;
    drv(1, 'hF, 3, 64'h55555555, 1, 3, 1, 5); cycle();
    chk("rstpri.rd1", 64'(if0.rd1), 64'h0);
    chk("rstpri.rd2", 64'(if0.rd2), 64'h0);
    s_rst = 1'b0;
    drv(0, 0, 0, 64'h0, 1, 3, 1, 5); cycle();
    chk("rstpri.lost", 64'(if0.rd1), 64'h0);
    chk("rstpri.clr", 64'(if0.rd2), 64'h0);

    for (int i = 0; i < 2000; i++) begin
      int wa, r1;
      s_rst = ($urandom_range(99) == 0);
      wa = int'($urandom_range(31));
      r1 = ($urandom_range(3) == 0) ? wa : int'($urandom_range(31));
      drv(int'($urandom_range(1)), int'($urandom_range(255)), wa, {$urandom, $urandom},
          int'($urandom_range(1)), r1, int'($urandom_range(1)), int'($urandom_range(31)));
      cycle();
    end

    drv(0, 0, 0, 64'h0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file: the successor to the team's single 32-bit reset-able D register. It holds DEPTH words of WIDTH bits and provides one write port with byte enables and two registered read ports. Optional write-to-read forwarding and a hard-wired zero register let it serve directly as the datapath register file of the team's processor assignments.

## Interface
- WIDTH, 32, data word width in bits; must be a multiple of 8
- DEPTH, 32, number of words (2..256; need not be a power of 2)
- AW, clog2(DEPTH), address width (derived, not overridden)
- ZERO_REG, 1, 1 = address 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns the new data
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset; sampled on rising clk
- we  input  1  write enable
- be  input  WIDTH/8  byte enables for the write; bit i covers wdata[8i+7:8i]
- waddr  input  AW  write address
- wdata  input  WIDTH  write data
- re1, re2  input  1  read enable, ports 1/2
- ra1, ra2  input  AW  read address, ports 1/2
- rd1, rd2  output  WIDTH  registered read data, ports 1/2

## Operation
- Single clock domain, synchronous active-high reset. Reset dominates we, re1 and re2.
- Reset: on a rising clk with reset=1, all DEPTH words become 0 and rd1 = rd2 = 0.
- Write: on a rising clk with reset=0, we=1, waddr < DEPTH, and not (ZERO_REG=1 and waddr=0):
  - mem[waddr] byte i <= wdata byte i for each be[i]=1; other bytes hold.
  - we=1 with be=0 changes nothing.
- Out-of-range or zero-register writes are silently dropped; no error output.
- Read, port p: on a rising clk with reset=0 and rep=1, rdp loads the value selected in this priority order:
  - 0, if rap >= DEPTH, or ZERO_REG=1 and rap=0.
  - The merged value, if BYPASS=1, the write above is taking effect, and waddr = rap. The merged value is mem[waddr] with the enabled bytes replaced by wdata, i.e. exactly the word being stored.
  - Otherwise mem[rap] as it was before this edge. With BYPASS=0 this is the old value.
- rep=0: rdp holds its previous value, including across writes to rap.
- Ports are independent. Both may read the same address, and both may bypass in the same cycle.
- No state machine beyond the storage array and the two output registers. Combinational paths from inputs to rd1/rd2 are forbidden.

## Timing
- Write latency: data is visible in mem after 1 rising edge. A non-bypassed read issued on the next edge returns it.
- Read latency: 1 cycle. ra/re are sampled on edge N and rd is valid after edge N, stable until the next enabled edge.
- Read of the write address in the same cycle:
  - BYPASS=1: new data after edge N.
  - BYPASS=0: old data after edge N, new data only if re-read on edge N+1.
- Reset asserted mid-stream: the edge where reset=1 clears everything. A write or read presented on that edge is discarded. The first edge with reset=0 operates normally.
- Reset de-assertion needs no recovery cycles.
- All outputs are 0 from the first reset edge until the first enabled read.

## Test plan
- Reset and basic write/read (WIDTH=32, DEPTH=32):
  - Reset 2 cycles -> rd1=rd2=0.
  - Write 0xA213D22F to addr 5 with be=0xF, then read ra1=5 next cycle -> rd1=0xA213D22F one edge later.
- Byte enables:
  - addr 5 holds 0xA213D22F; write 0x3324DFA1 with be=0b0101 -> addr 5 = 0xA224D2A1.
  - be=0 write -> no change.
- Bypass:
  - Same cycle: we=1, waddr=7, wdata=0x12353ABC, ra1=ra2=7, re1=re2=1.
  - BYPASS=1 -> rd1=rd2=0x12353ABC after that edge.
  - BYPASS=0 (rebuilt) -> old value after that edge, 0x12353ABC after the next read.
- Zero register and range (DEPTH=20, ZERO_REG=1):
  - Write 0xFFFFFFFF to addr 0 and to addr 25; read ra1=0, ra2=25 -> both 0.
  - Addr 19 stays writable and readable.
- Read hold and reset priority:
  - rd1=0xDEADBEEF with re1=0 while addr 3 is rewritten -> rd1 stays 0xDEADBEEF.
  - Assert reset together with we=1 and re1=1 -> all words and rd1/rd2 = 0; the write is lost.
- Randomised scoreboard (WIDTH=64, DEPTH=16, both BYPASS settings):
  - 2000 cycles of random we, be, addresses and data checked against a reference model.
  - Zero mismatches required.
